// File: rtl/hyperbus_target.sv
// hyperbus_target: HyperRAM device emulator that answers a HyperBus controller.
// All HyperBus pins are sampled in the clk domain. The 48-bit command/address is
// decoded, the initial latency is counted, and then reads and writes go to an
// internal 16-bit word memory or to the ID/configuration registers.
//
// Ports
//   clk, rstn          system clock (at least 4x hbus_ck), async active-low reset
//   hbus_ck            bus clock, sampled as data; either edge is one beat
//   hbus_csn           chip select, active low
//   hbus_rstn          bus reset: aborts like csn high and restores CR0/CR1
//   hbus_dq_i/_o/_oe   DQ byte lane from host / to host / drive enable
//   hbus_rwds_i        write byte mask from host (1 = masked)
//   hbus_rwds_o/_oe    RWDS to host / drive enable
//   busy               a transaction is in progress
`timescale 1ns/1ps
module hyperbus_target #(
    parameter int unsigned MEM_AW     = 10,
    parameter int unsigned TACC_COUNT = 7,
    parameter logic [15:0] ID0        = 16'h0C81,
    parameter logic [15:0] ID1        = 16'h0001,
    parameter logic [15:0] CR0_INIT   = 16'h8F1F,
    parameter logic [15:0] CR1_INIT   = 16'hFFC1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       hbus_ck,
    input  logic       hbus_csn,
    input  logic       hbus_rstn,
    input  logic [7:0] hbus_dq_i,
    output logic [7:0] hbus_dq_o,
    output logic       hbus_dq_oe,
    input  logic       hbus_rwds_i,
    output logic       hbus_rwds_o,
    output logic       hbus_rwds_oe,
    output logic       busy
);
    typedef enum logic [2:0] {StIdle, StCa, StLat, StRd, StWr} state_e;

    localparam logic [7:0] Lat1x = 8'(2 * TACC_COUNT);
    localparam logic [7:0] Lat2x = 8'(4 * TACC_COUNT);

    logic        ck_q, ck_qq, csn_q, brstn_q, rwds_q;
    logic [7:0]  dq_q;
    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [39:0] ca_q, ca_d;
    logic [7:0]  lat_q, lat_d;
    logic [31:0] addr_q, addr_d, addr_next;
    logic        rd_q, rd_d, reg_q, reg_d, lin_q, lin_d, hi_q, hi_d;
    logic [7:0]  wbyte_q, wbyte_d;
    logic        wmask_q, wmask_d;
    logic [15:0] cr0_q, cr0_d, cr1_q, cr1_d;
    logic [7:0]  dq_o_q, dq_o_d;
    logic        dq_oe_q, dq_oe_d, rwds_o_q, rwds_o_d, rwds_oe_q, rwds_oe_d;

    logic [15:0] mem_q [2**MEM_AW];
    logic [15:0] rdata_q, reg_word, rd_word, wword;
    logic [1:0]  be;
    logic        mem_we, beat;
    logic [47:0] ca_full;
    logic        unused_ca;

    assign beat      = ck_q ^ ck_qq;
    assign ca_full   = {ca_q, dq_q};
    assign unused_ca = ^ca_full[15:3];
    assign wword     = {wbyte_q, dq_q};
    assign be        = ~{wmask_q, rwds_q};
    // Wrapped bursts stay inside the aligned 16-word group.
    assign addr_next = lin_q ? addr_q + 32'd1 : {addr_q[31:4], addr_q[3:0] + 4'd1};

    always_comb begin
        reg_word = 16'h0000;
        if (addr_q == 32'h0000_0000)      reg_word = ID0;
        else if (addr_q == 32'h0000_0001) reg_word = ID1;
        else if (addr_q == 32'h0000_0800) reg_word = cr0_q;
        else if (addr_q == 32'h0000_0801) reg_word = cr1_q;
    end

    assign rd_word = reg_q ? reg_word : rdata_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ca_d      = ca_q;
        lat_d     = lat_q;
        addr_d    = addr_q;
        rd_d      = rd_q;
        reg_d     = reg_q;
        lin_d     = lin_q;
        hi_d      = hi_q;
        wbyte_d   = wbyte_q;
        wmask_d   = wmask_q;
        cr0_d     = cr0_q;
        cr1_d     = cr1_q;
        dq_o_d    = dq_o_q;
        dq_oe_d   = dq_oe_q;
        rwds_o_d  = rwds_o_q;
        rwds_oe_d = rwds_oe_q;
        mem_we    = 1'b0;

        if (!brstn_q) begin
            cr0_d = CR0_INIT;
            cr1_d = CR1_INIT;
        end

        if (state_q != StIdle && (csn_q || !brstn_q)) begin
            // Abort: a half-received write word is simply never committed.
            state_d   = StIdle;
            dq_o_d    = 8'h00;
            dq_oe_d   = 1'b0;
            rwds_o_d  = 1'b0;
            rwds_oe_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!csn_q && brstn_q) begin
                        state_d   = StCa;
                        cnt_d     = 3'd0;
                        rwds_oe_d = 1'b1;
                        rwds_o_d  = cr0_q[3];
                    end
                end
                StCa: begin
                    if (beat) begin
                        ca_d  = ca_full[39:0];
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd5) begin
                            addr_d   = {ca_full[44:16], ca_full[2:0]};
                            rd_d     = ca_full[47];
                            reg_d    = ca_full[46];
                            lin_d    = ca_full[45];
                            hi_d     = 1'b1;
                            rwds_o_d = 1'b0;
                            if (!ca_full[47] && ca_full[46]) begin
                                state_d   = StWr;
                                rwds_oe_d = 1'b0;
                            end else begin
                                state_d   = StLat;
                                lat_d     = cr0_q[3] ? Lat2x : Lat1x;
                                rwds_oe_d = ca_full[47];
                            end
                        end
                    end
                end
                StLat: begin
                    if (beat) begin
                        lat_d = lat_q - 8'd1;
                        if (lat_q == 8'd1) begin
                            if (rd_q) begin
                                // First byte goes out on the last latency beat.
                                state_d  = StRd;
                                dq_oe_d  = 1'b1;
                                dq_o_d   = rd_word[15:8];
                                rwds_o_d = 1'b1;
                                hi_d     = 1'b0;
                            end else begin
                                state_d = StWr;
                            end
                        end
                    end
                end
                StRd: begin
                    if (beat) begin
                        rwds_o_d = ~rwds_o_q;
                        if (hi_q) begin
                            dq_o_d = rd_word[15:8];
                            hi_d   = 1'b0;
                        end else begin
                            // rdata_q refetches the next word before the next beat.
                            dq_o_d = rd_word[7:0];
                            hi_d   = 1'b1;
                            addr_d = addr_next;
                        end
                    end
                end
                StWr: begin
                    if (beat) begin
                        if (hi_q) begin
                            wbyte_d = dq_q;
                            wmask_d = rwds_q;
                            hi_d    = 1'b0;
                        end else begin
                            hi_d   = 1'b1;
                            addr_d = addr_next;
                            if (!reg_q) begin
                                mem_we = 1'b1;
                            end else if (addr_q == 32'h0000_0800) begin
                                cr0_d = {be[1] ? wword[15:8] : cr0_q[15:8],
                                         be[0] ? wword[7:0]  : cr0_q[7:0]};
                            end else if (addr_q == 32'h0000_0801) begin
                                cr1_d = {be[1] ? wword[15:8] : cr1_q[15:8],
                                         be[0] ? wword[7:0]  : cr1_q[7:0]};
                            end
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ck_q      <= 1'b0;
            ck_qq     <= 1'b0;
            csn_q     <= 1'b1;
            brstn_q   <= 1'b1;
            dq_q      <= 8'h00;
            rwds_q    <= 1'b0;
            state_q   <= StIdle;
            cnt_q     <= 3'd0;
            ca_q      <= 40'd0;
            lat_q     <= 8'd0;
            addr_q    <= 32'd0;
            rd_q      <= 1'b0;
            reg_q     <= 1'b0;
            lin_q     <= 1'b0;
            hi_q      <= 1'b1;
            wbyte_q   <= 8'h00;
            wmask_q   <= 1'b0;
            cr0_q     <= CR0_INIT;
            cr1_q     <= CR1_INIT;
            dq_o_q    <= 8'h00;
            dq_oe_q   <= 1'b0;
            rwds_o_q  <= 1'b0;
            rwds_oe_q <= 1'b0;
        end else begin
            ck_q      <= hbus_ck;
            ck_qq     <= ck_q;
            csn_q     <= hbus_csn;
            brstn_q   <= hbus_rstn;
            dq_q      <= hbus_dq_i;
            rwds_q    <= hbus_rwds_i;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ca_q      <= ca_d;
            lat_q     <= lat_d;
            addr_q    <= addr_d;
            rd_q      <= rd_d;
            reg_q     <= reg_d;
            lin_q     <= lin_d;
            hi_q      <= hi_d;
            wbyte_q   <= wbyte_d;
            wmask_q   <= wmask_d;
            cr0_q     <= cr0_d;
            cr1_q     <= cr1_d;
            dq_o_q    <= dq_o_d;
            dq_oe_q   <= dq_oe_d;
            rwds_o_q  <= rwds_o_d;
            rwds_oe_q <= rwds_oe_d;
        end
    end

    // Memory contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            if (be[1]) mem_q[addr_q[MEM_AW-1:0]][15:8] <= wword[15:8];
            if (be[0]) mem_q[addr_q[MEM_AW-1:0]][7:0]  <= wword[7:0];
        end
        rdata_q <= mem_q[addr_q[MEM_AW-1:0]];
    end

    assign hbus_dq_o    = dq_o_q;
    assign hbus_dq_oe   = dq_oe_q;
    assign hbus_rwds_o  = rwds_o_q;
    assign hbus_rwds_oe = rwds_oe_q;
    assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_hyperbus_target.sv
// Directed bench for hyperbus_target: a host model toggles hbus_ck every four clk
// cycles and samples the target's registered outputs just after each bus edge.
`timescale 1ns/1ps
module tb_hyperbus_target;
    localparam int HALF = 4;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       hbus_ck = 1'b0;
    logic       hbus_csn = 1'b1;
    logic       hbus_rstn = 1'b1;
    logic [7:0] hbus_dq_i = 8'h00;
    logic [7:0] hbus_dq_o;
    logic       hbus_dq_oe;
    logic       hbus_rwds_i = 1'b0;
    logic       hbus_rwds_o;
    logic       hbus_rwds_oe;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] wd [16];
    logic [1:0]  wm [16];
    logic [7:0]  rb [32];
    logic        rr [32];

    hyperbus_target dut (
        .clk          (clk),
        .rstn         (rstn),
        .hbus_ck      (hbus_ck),
        .hbus_csn     (hbus_csn),
        .hbus_rstn    (hbus_rstn),
        .hbus_dq_i    (hbus_dq_i),
        .hbus_dq_o    (hbus_dq_o),
        .hbus_dq_oe   (hbus_dq_oe),
        .hbus_rwds_i  (hbus_rwds_i),
        .hbus_rwds_o  (hbus_rwds_o),
        .hbus_rwds_oe (hbus_rwds_oe),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [47:0] make_ca(input logic r, input logic s, input logic l,
                                            input logic [31:0] a);
        make_ca = {r, s, l, a[31:3], 13'd0, a[2:0]};
    endfunction

    task automatic ck_edge(input logic [7:0] d, input logic m);
        hbus_dq_i   = d;
        hbus_rwds_i = m;
        hbus_ck     = ~hbus_ck;
        repeat (HALF) @(posedge clk);
        #1;
    endtask

    task automatic send_ca(input logic [47:0] ca, input logic exp_rwds);
        hbus_csn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            ck_edge(ca[47-8*i -: 8], 1'b0);
            if (i == 2) check_eq("ca_rwds", {hbus_rwds_oe, hbus_rwds_o}, {1'b1, exp_rwds});
        end
    endtask

    task automatic lat_edges(input int n);
        for (int i = 0; i < n; i++) begin
            if (i == n - 1) check_eq("lat_dq_oe", 32'(hbus_dq_oe), 32'd0);
            ck_edge(8'h00, 1'b0);
        end
    endtask

    task automatic end_txn();
        hbus_csn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic rd_txn(input logic [47:0] ca, input logic exp_rwds, input int lat,
                          input int nbytes);
        send_ca(ca, exp_rwds);
        lat_edges(lat);
        check_eq("rd_dq_oe", 32'(hbus_dq_oe), 32'd1);
        for (int i = 0; i < nbytes; i++) begin
            rb[i] = hbus_dq_o;
            rr[i] = hbus_rwds_o;
            if (i < nbytes - 1) ck_edge(8'h00, 1'b0);
        end
        end_txn();
    endtask

    task automatic wr_txn(input logic [47:0] ca, input logic exp_rwds, input int lat,
                          input int nwords);
        send_ca(ca, exp_rwds);
        lat_edges(lat);
        for (int i = 0; i < nwords; i++) begin
            ck_edge(wd[i][15:8], wm[i][1]);
            ck_edge(wd[i][7:0], wm[i][0]);
        end
        end_txn();
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_dq_o", 32'(hbus_dq_o), 32'h00);
        check_eq("rst_dq_oe", 32'(hbus_dq_oe), 32'd0);
        check_eq("rst_rwds_o", 32'(hbus_rwds_o), 32'd0);
        check_eq("rst_rwds_oe", 32'(hbus_rwds_oe), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // ID0 register read, 2x latency of 28 edges
        rd_txn(48'hC000_0000_0000, 1'b1, 28, 2);
        check_eq("id0_hi", 32'(rb[0]), 32'h0C);
        check_eq("id0_lo", 32'(rb[1]), 32'h81);
        check_eq("id0_rwds0", 32'(rr[0]), 32'd1);
        check_eq("id0_rwds1", 32'(rr[1]), 32'd0);

        // Linear write of two words at 0x010, then read back
        wd[0] = 16'h1234; wm[0] = 2'b00;
        wd[1] = 16'h5678; wm[1] = 2'b00;
        wr_txn(make_ca(1'b0, 1'b0, 1'b1, 32'h010), 1'b1, 28, 2);
        rd_txn(make_ca(1'b1, 1'b0, 1'b1, 32'h010), 1'b1, 28, 4);
        check_eq("lin_b0", 32'(rb[0]), 32'h12);
        check_eq("lin_b1", 32'(rb[1]), 32'h34);
        check_eq("lin_b2", 32'(rb[2]), 32'h56);
        check_eq("lin_b3", 32'(rb[3]), 32'h78);
        check_eq("lin_rwds", {28'd0, rr[0], rr[1], rr[2], rr[3]}, 32'b1010);

        // Upper byte masked: 0x1234 <- 0xAABB gives 0x12BB
        wd[0] = 16'hAABB; wm[0] = 2'b10;
        wr_txn(make_ca(1'b0, 1'b0, 1'b1, 32'h010), 1'b1, 28, 1);
        rd_txn(make_ca(1'b1, 1'b0, 1'b1, 32'h010), 1'b1, 28, 2);
        check_eq("mask_word", {16'd0, rb[0], rb[1]}, 32'h12BB);

        // csn raised after upper byte: 0x011 keeps 0x5678
        send_ca(make_ca(1'b0, 1'b0, 1'b1, 32'h011), 1'b1);
        lat_edges(28);
        ck_edge(8'hEE, 1'b0);
        hbus_csn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("abort_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rd_txn(make_ca(1'b1, 1'b0, 1'b1, 32'h011), 1'b1, 28, 2);
        check_eq("abort_word", {16'd0, rb[0], rb[1]}, 32'h5678);

        // Preload 0x010..0x01F with own address, wrapped read from 0x01E
        for (int i = 0; i < 16; i++) begin
            wd[i] = 16'h0010 + 16'(i);
            wm[i] = 2'b00;
        end
        wr_txn(make_ca(1'b0, 1'b0, 1'b1, 32'h010), 1'b1, 28, 16);
        rd_txn(make_ca(1'b1, 1'b0, 1'b0, 32'h01E), 1'b1, 28, 6);
        check_eq("wrap_w0", {16'd0, rb[0], rb[1]}, 32'h001E);
        check_eq("wrap_w1", {16'd0, rb[2], rb[3]}, 32'h001F);
        check_eq("wrap_w2", {16'd0, rb[4], rb[5]}, 32'h0010);

        // CR0 = 0x8F17 selects 1x latency: 14 edges, rwds low during CA
        wd[0] = 16'h8F17; wm[0] = 2'b00;
        wr_txn(make_ca(1'b0, 1'b1, 1'b0, 32'h800), 1'b1, 0, 1);
        rd_txn(make_ca(1'b1, 1'b0, 1'b1, 32'h011), 1'b0, 14, 2);
        check_eq("lat1x_word", {16'd0, rb[0], rb[1]}, 32'h0011);

        // System reset in the middle of a read
        send_ca(make_ca(1'b1, 1'b0, 1'b1, 32'h012), 1'b0);
        lat_edges(14);
        check_eq("midrd_dq_oe", 32'(hbus_dq_oe), 32'd1);
        ck_edge(8'h00, 1'b0);
        rstn = 1'b0;
        #1;
        check_eq("rst_mid_oe", {30'd0, hbus_dq_oe, hbus_rwds_oe}, 32'd0);
        check_eq("rst_mid_busy", 32'(busy), 32'd0);
        hbus_csn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        rd_txn(make_ca(1'b1, 1'b1, 1'b0, 32'h800), 1'b1, 28, 2);
        check_eq("cr0_restored", {16'd0, rb[0], rb[1]}, 32'h8F1F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hyperbus_target.md
# hyperbus_target

Synthesizable HyperBus responder (HyperRAM device emulator) for the far end of the `hyperbus` controller. It samples the HyperBus pins in a single fast system clock domain, decodes the 48-bit command/address, applies initial latency, and serves reads and writes from an internal 16-bit-word memory plus ID/configuration registers. It is used in loopback benches and on FPGA builds without a physical HyperRAM.

## Interface
- `MEM_AW`, 10: word-address width of internal memory (2^MEM_AW x 16 bit).
- `TACC_COUNT`, 7: latency count L in hbus_ck cycles (1x).
- `ID0`, 16'h0C81: value of register word 0x000.
- `ID1`, 16'h0001: value of register word 0x001.
- `CR0_INIT`, 16'h8F1F: reset value of CR0 (word 0x800); bit 3 = 1 selects fixed 2x latency.
- `CR1_INIT`, 16'hFFC1: reset value of CR1 (word 0x801).

Ports:
- `clk` in 1: system clock, at least 4x hbus_ck frequency.
- `rstn` in 1: asynchronous, active-low reset.
- `hbus_ck` in 1: bus clock, sampled as data.
- `hbus_csn` in 1: chip select, active low.
- `hbus_rstn` in 1: bus reset; low behaves like csn high (abort) and restores CR0/CR1.
- `hbus_dq_i` in 8: DQ from host.
- `hbus_dq_o` out 8: DQ to host.
- `hbus_dq_oe` out 1: DQ drive enable.
- `hbus_rwds_i` in 1: RWDS from host (write mask, 1 = masked).
- `hbus_rwds_o` out 1: RWDS to host.
- `hbus_rwds_oe` out 1: RWDS drive enable.
- `busy` out 1: state != IDLE.

## Operation
- `hbus_ck`, `hbus_csn`, `hbus_rstn`, `hbus_dq_i`, `hbus_rwds_i` each registered once (q), ck registered twice (qq). Beat = cycle where ck_q != ck_qq (either edge); DQ/RWDS captured from the q stage in that cycle.
- States: IDLE, CA, LAT, RD, WR, WAIT.
- IDLE: csn_q low -> CA, beat counter = 0.
- CA: 6 beats shift into ca[47:0], MSB byte first. During CA drive rwds_oe=1, rwds_o=CR0[3]. After 6th beat: word address A = {ca[44:16], ca[2:0]}; ca[47] = read, ca[46] = register space, ca[45] = linear (1) / wrapped (0).
  - Register write (ca[47]=0, ca[46]=1): -> WR, zero latency.
  - Otherwise -> LAT, edge count = 2*L*(CR0[3] ? 2 : 1).
- LAT: decrement on each beat; at 0 -> RD or WR. Reads: rwds_oe=1, rwds_o=0. Writes: rwds_oe=0.
- RD: dq_oe=1, rwds_oe=1. On the final LAT beat and on each RD beat, present the next byte (upper byte of word first) and toggle rwds_o (first byte rwds_o=1). Word address advances after the lower byte.
- WR: rwds_oe=0, dq_oe=0. Upper byte, then lower byte. A word commits after the lower beat with per-byte enables = ~rwds captured per beat. Register writes commit only to 0x800/0x801; other addresses are ignored.
- Address advance: linear wraps modulo 2^MEM_AW. Wrapped stays within the aligned 16-word group (A[3:0] increments mod 16).
- Register reads: 0x000=ID0, 0x001=ID1, 0x800=CR0, 0x801=CR1, otherwise 16'h0000. Memory uses the low MEM_AW bits of A.
- csn_q high or hbus_rstn_q low in any non-IDLE state -> IDLE next clk, all oe=0. Half-received write word is discarded. Committed words are kept.
- WAIT is not required by any transition; an implementation may omit it.

## Timing
- Reset (rstn low): state IDLE, dq_o=0, dq_oe=0, rwds_o=0, rwds_oe=0, busy=0, CR0=CR0_INIT, CR1=CR1_INIT. Memory is not reset.
- Beat detected in clk cycle k -> outputs change at k+1 (registered outputs).
- Memory read is registered. The next word is fetched while the current lower byte is presented, so the following beat always has valid data with hbus_ck half-period >= 2 clk.
- busy rises the cycle after csn_q falls and falls the cycle after csn_q rises.
- Total read edges before first data with CR0[3]=1, L=7: 6 CA + 28 latency; first byte is valid one clk after edge 34.

## Test plan
- Register read 0x000 (CA 0xC0_00_00_00_00_00) -> bytes 0x0C, 0x81; rwds_o high during CA; 28 latency edges.
- Linear write at A=0x010 with words 0x1234, 0x5678, then linear read of 2 words -> 0x12, 0x34, 0x56, 0x78, rwds_o toggling 1, 0, 1, 0.
- Wrapped read of 3 words starting at A=0x01E (memory preloaded with its address) -> 0x001E, 0x001F, 0x0010.
- Masked write 0xAABB to a word holding 0x1234 with rwds 1 then 0 -> readback 0x12BB.
- Register write CR0=0x8F17 (bit3=0), then memory read -> rwds_o low during CA, 14 latency edges. Assert rstn low mid-read -> all oe=0 immediately and CR0 back to 0x8F1F.
- csn raised after upper byte of a write -> target word unchanged, busy=0 the next clk.
